// File: rtl/serial_paralelo_alineador_if.sv
// serial_paralelo_alineador_if
//   Bundles the serial input and the aligned-word outputs of the comma-aligning
//   deserializer.
//   master : drives entrada, observes the aligned word and status (link source / bench)
//   slave  : the deserializer itself
//   entrada         serial bit, word bit 9 first
//   salidas         last aligned 10-bit word
//   validSalida     one-cycle strobe, salidas updated
//   esComa          salidas holds a K28.5 comma
//   alineado        word alignment established
//   errorAlineacion one-cycle pulse on loss of alignment
interface serial_paralelo_alineador_if;
   logic       entrada;
   logic [9:0] salidas;
   logic       validSalida;
   logic       esComa;
   logic       alineado;
   logic       errorAlineacion;

   modport master (output entrada,
                   input  salidas, validSalida, esComa, alineado, errorAlineacion);
   modport slave  (input  entrada,
                   output salidas, validSalida, esComa, alineado, errorAlineacion);
endinterface

// File: rtl/serial_paralelo_alineador.sv
// serial_paralelo_alineador
//   Receive-side deserializer for the 10-bit serial link. Shifts the bit stream
//   into a 10-bit window, hunts for K28.5 commas, and once COMAS consecutive
//   commas land on the same word phase it emits every aligned word.
//   Ports:
//     clk         one serial bit per rising edge
//     rstContador asynchronous, active-low reset
//     bus         slave side of serial_paralelo_alineador_if (entrada in,
//                 salidas/validSalida/esComa/alineado/errorAlineacion out)
module serial_paralelo_alineador #(
   parameter int         COMAS    = 3,
   parameter logic [9:0] COMA_NEG = 10'b0011111010,
   parameter logic [9:0] COMA_POS = 10'b1100000101
) (
   input logic                        clk,
   input logic                        rstContador,
   serial_paralelo_alineador_if.slave bus
);

   localparam logic [3:0] COMAS_L = 4'(COMAS);

   typedef enum logic [1:0] {BUSCANDO, CONFIRMANDO, ALINEADO} estado_t;

   estado_t    estado, estadoSig;
   logic [9:0] sr;
   logic [3:0] fase, faseSig;
   logic [3:0] cuenta, cuentaSig;
   logic [9:0] salidasR, salidasSig;
   logic       validR, validSig;
   logic       esComaR, esComaSig;
   logic       errR, errSig;
   logic       alineadoR;
   logic       hit, frontera;

   // The window holds a complete word during the cycle where fase == 9; the
   // decision about that word is taken on the following edge.
   assign hit      = (sr == COMA_NEG) || (sr == COMA_POS);
   assign frontera = (fase == 4'd9);

   always_comb begin
      estadoSig  = estado;
      cuentaSig  = cuenta;
      faseSig    = frontera ? 4'd0 : fase + 4'd1;
      salidasSig = salidasR;
      esComaSig  = esComaR;
      validSig   = 1'b0;
      errSig     = 1'b0;
      case (estado)
         BUSCANDO: begin
            if (hit) begin
               // Treat the hit cycle itself as a boundary from now on.
               faseSig   = 4'd0;
               cuentaSig = 4'd1;
               if (COMAS_L == 4'd1) begin
                  estadoSig  = ALINEADO;
                  salidasSig = sr;
                  esComaSig  = 1'b1;
                  validSig   = 1'b1;
               end else begin
                  estadoSig = CONFIRMANDO;
               end
            end
         end
         CONFIRMANDO: begin
            if (frontera && hit) begin
               cuentaSig = cuenta + 4'd1;
               if (cuenta + 4'd1 == COMAS_L) begin
                  // The confirming comma is delivered as the first word.
                  estadoSig  = ALINEADO;
                  salidasSig = sr;
                  esComaSig  = 1'b1;
                  validSig   = 1'b1;
               end
            end else if (hit) begin
               // Comma at a new phase: restart the count there.
               cuentaSig = 4'd1;
               faseSig   = 4'd0;
            end
         end
         ALINEADO: begin
            if (frontera) begin
               salidasSig = sr;
               esComaSig  = hit;
               validSig   = 1'b1;
            end else if (hit) begin
               errSig    = 1'b1;
               estadoSig = CONFIRMANDO;
               cuentaSig = 4'd1;
               faseSig   = 4'd0;
            end
         end
         default: estadoSig = BUSCANDO;
      endcase
   end

   always_ff @(posedge clk or negedge rstContador) begin
      if (!rstContador) begin
         estado    <= BUSCANDO;
         sr        <= '0;
         fase      <= '0;
         cuenta    <= '0;
         salidasR  <= '0;
         validR    <= 1'b0;
         esComaR   <= 1'b0;
         errR      <= 1'b0;
         alineadoR <= 1'b0;
      end else begin
         estado    <= estadoSig;
         sr        <= {sr[8:0], bus.entrada};
         fase      <= faseSig;
         cuenta    <= cuentaSig;
         salidasR  <= salidasSig;
         validR    <= validSig;
         esComaR   <= esComaSig;
         errR      <= errSig;
         alineadoR <= (estadoSig == ALINEADO);
      end
   end

   assign bus.salidas         = salidasR;
   assign bus.validSalida     = validR;
   assign bus.esComa          = esComaR;
   assign bus.alineado        = alineadoR;
   assign bus.errorAlineacion = errR;

endmodule
